// File: rtl/memory_controller_pkg.sv
// Shared definitions for the memory controller: data-port command codes,
// controller state encodings and the command decode rule.
package memory_controller_pkg;

  localparam logic [1:0] MEM_IDLE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DATA  = 3'd1,
    TURN  = 3'd2,
    FETCH = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Code 2'b11 is deliberately not an access: it behaves exactly like idle.
  function automatic logic is_access(input logic [1:0] control);
    return (control == MEM_READ) || (control == MEM_WRITE);
  endfunction

endpackage

// File: rtl/memory_controller_sram_access_counter.sv
// Down-counter that times one SRAM access window; last is high in the
// final cycle of the window.
module sram_access_counter (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [2:0] load_value,
  output logic       last
);

  logic [2:0] count;

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values of all the others, regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= 3'd0;
    end else if (load) begin
      count <= load_value;
    end else if (count != 3'd0) begin
      count <= count - 3'd1;
    end
  end

  assign last = (count == 3'd0);

endmodule

// File: rtl/memory_controller.sv
// Arbitrates the CPU fetch and data ports onto one asynchronous SRAM and
// sequences its CE/OE/WE strobes; data access always precedes the fetch.
module memory_controller
  import memory_controller_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  if_request,
  input  logic [ADDR_WIDTH-1:0] if_address,
  output logic [DATA_WIDTH-1:0] if_data,
  input  logic [1:0]            mem_control,
  input  logic [ADDR_WIDTH-1:0] mem_address,
  input  logic [DATA_WIDTH-1:0] mem_target_value,
  output logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  cpu_stall,
  output logic [ADDR_WIDTH-1:0] sram_address,
  output logic [DATA_WIDTH-1:0] sram_data_out,
  input  logic [DATA_WIDTH-1:0] sram_data_in,
  output logic                  sram_data_oe,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n
);

  // A write always needs one we_n-low cycle plus one hold cycle.
  localparam logic [2:0] READ_LOAD  = 3'(WAIT_CYCLES);
  localparam logic [2:0] WRITE_LOAD = (WAIT_CYCLES == 0) ? 3'd1 : 3'(WAIT_CYCLES);

  state_t                state, next_state;
  logic                  write_q, fetch_q;
  logic [ADDR_WIDTH-1:0] mem_address_q, if_address_q;
  logic [DATA_WIDTH-1:0] write_data_q;
  logic                  load, last;
  logic [2:0]            load_value;

  sram_access_counter u_counter (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .load_value (load_value),
    .last       (last)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    next_state = state;
    load_value = READ_LOAD;
    unique case (state)
      IDLE: begin
        if (is_access(mem_control)) begin
          next_state = DATA;
          if (mem_control == MEM_WRITE) load_value = WRITE_LOAD;
        end else if (if_request) begin
          next_state = FETCH;
        end
      end
      DATA:    if (last) next_state = fetch_q ? (write_q ? TURN : FETCH) : DONE;
      TURN:    next_state = FETCH;
      FETCH:   if (last) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    load = (next_state != state) && ((next_state == DATA) || (next_state == FETCH));
  end

  always_comb begin
    sram_ce_n    = 1'b1;
    sram_oe_n    = 1'b1;
    sram_we_n    = 1'b1;
    sram_data_oe = 1'b0;
    if (state == DATA) begin
      sram_ce_n = 1'b0;
      if (write_q) begin
        sram_data_oe = 1'b1;
        sram_we_n    = last;
      end else begin
        sram_oe_n = 1'b0;
      end
    end else if (state == FETCH) begin
      sram_ce_n = 1'b0;
      sram_oe_n = 1'b0;
    end
  end

  assign sram_address  = (state == FETCH) ? if_address_q : mem_address_q;
  assign sram_data_out = write_data_q;
  assign cpu_stall     = (if_request || is_access(mem_control)) && (state != DONE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      write_q       <= 1'b0;
      fetch_q       <= 1'b0;
      mem_address_q <= '0;
      if_address_q  <= '0;
      write_data_q  <= '0;
      if_data       <= '0;
      mem_read_data <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE) begin
        if (is_access(mem_control)) begin
          write_q       <= (mem_control == MEM_WRITE);
          fetch_q       <= if_request;
          mem_address_q <= mem_address;
          write_data_q  <= mem_target_value;
          if_address_q  <= if_address;
        end else if (if_request) begin
          if_address_q <= if_address;
        end
      end
      if (state == DATA && !write_q && last) mem_read_data <= sram_data_in;
      if (state == FETCH && last) if_data <= sram_data_in;
    end
  end

endmodule
